bounce_engine: RTL and testbench



---
 rtl/screensaver_pkg.sv | 32 +++
 rtl/axis_step.sv | 39 +++
 rtl/bounce_engine.sv | 117 +++++++++++
 tb/tb_bounce_engine.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/screensaver_pkg.sv
// Shared constants and types for the bouncing-box motion stage.
// Velocities are 4-bit signed and are kept within -7..+7, so negating one never overflows.
package screensaver_pkg;

    localparam int SCREEN_WIDTH  = 640;
    localparam int SCREEN_HEIGHT = 480;
    localparam int BOX_WIDTH     = 100;
    localparam int BOX_HEIGHT    = 100;

    localparam int X_LIMIT = SCREEN_WIDTH - BOX_WIDTH;
    localparam int Y_LIMIT = SCREEN_HEIGHT - BOX_HEIGHT;
    localparam int X_W     = 10;
    localparam int Y_W     = 9;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CALC_X = 2'd1,
        CALC_Y = 2'd2,
        COMMIT = 2'd3
    } bounce_state_t;

    typedef logic [2:0]        color_t;
    typedef logic signed [3:0] vel_t;

    // Advance the colour only on a bounce; 7 wraps to 1 so black never appears.
    function automatic color_t next_color(input color_t c, input logic step);
        if (!step)
            return c;
        return (c == 3'd7) ? 3'd1 : c + 3'd1;
    endfunction

endpackage

// File: rtl/axis_step.sv
// Combinational clamp-and-reflect for one axis: (pos, vel) -> (npos, nvel, hit).
// A stationary axis never reports a hit, even when it already sits on the limit.
module axis_step
    import screensaver_pkg::*;
#(
    parameter int POS_W = 10,
    parameter int LIMIT = 540
) (
    input  logic [POS_W-1:0] pos,
    input  vel_t             vel,
    output logic [POS_W-1:0] npos,
    output vel_t             nvel,
    output logic             hit
);

    localparam int TW = POS_W + 2;
    localparam logic signed [TW-1:0] LIM = TW'(LIMIT);

    logic signed [TW-1:0] traj;

    always_comb begin
        traj = $signed({2'b00, pos}) + $signed({{(TW-4){vel[3]}}, vel});
        npos = traj[POS_W-1:0];
        nvel = vel;
        hit  = 1'b0;
        if (vel != '0) begin
            if (traj < 0) begin
                npos = '0;
                nvel = -vel;
                hit  = 1'b1;
            end else if (traj >= LIM) begin
                npos = LIM[POS_W-1:0];
                nvel = -vel;
                hit  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bounce_engine.sv
// Per-frame motion stage: steps the box once per frame-counter change, reflecting at the edges.
// Results are held in shadow registers and published together in a single COMMIT cycle.
module bounce_engine
    import screensaver_pkg::*;
#(
    parameter int INIT_X  = 50,
    parameter int INIT_Y  = 50,
    parameter int INIT_XV = 2,
    parameter int INIT_YV = 1
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           enable,
    input  logic [31:0]    frame,
    output logic [X_W-1:0] box_x,
    output logic [Y_W-1:0] box_y,
    output color_t         color,
    output logic           busy,
    output logic           update_done,
    output logic           bounce
);

    bounce_state_t  state;
    logic [31:0]    frame_prev;
    vel_t           xv, yv;
    logic [X_W-1:0] nx;
    logic [Y_W-1:0] ny;
    vel_t           nxv, nyv;
    logic           hx, hy;

    logic [X_W-1:0] ax_npos;
    vel_t           ax_nvel;
    logic           ax_hit;
    logic [Y_W-1:0] ay_npos;
    vel_t           ay_nvel;
    logic           ay_hit;

    axis_step #(.POS_W(X_W), .LIMIT(X_LIMIT)) u_axis_x (
        .pos  (box_x),
        .vel  (xv),
        .npos (ax_npos),
        .nvel (ax_nvel),
        .hit  (ax_hit)
    );

    axis_step #(.POS_W(Y_W), .LIMIT(Y_LIMIT)) u_axis_y (
        .pos  (box_y),
        .vel  (yv),
        .npos (ay_npos),
        .nvel (ay_nvel),
        .hit  (ay_hit)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            frame_prev  <= '1;
            box_x       <= X_W'(INIT_X);
            box_y       <= Y_W'(INIT_Y);
            xv          <= vel_t'(INIT_XV);
            yv          <= vel_t'(INIT_YV);
            color       <= 3'b111;
            busy        <= 1'b0;
            update_done <= 1'b0;
            bounce      <= 1'b0;
            nx          <= '0;
            ny          <= '0;
            nxv         <= '0;
            nyv         <= '0;
            hx          <= 1'b0;
            hy          <= 1'b0;
        end else begin
            update_done <= 1'b0;
            bounce      <= 1'b0;
            case (state)
                IDLE: begin
                    // Frozen: keep tracking the counter so re-enabling does not replay a stale change.
                    if (!enable) begin
                        frame_prev <= frame;
                    end else if (frame != frame_prev) begin
                        frame_prev <= frame;
                        state      <= CALC_X;
                        busy       <= 1'b1;
                    end
                end
                CALC_X: begin
                    nx    <= ax_npos;
                    nxv   <= ax_nvel;
                    hx    <= ax_hit;
                    state <= CALC_Y;
                end
                CALC_Y: begin
                    ny    <= ay_npos;
                    nyv   <= ay_nvel;
                    hy    <= ay_hit;
                    state <= COMMIT;
                end
                COMMIT: begin
                    box_x       <= nx;
                    box_y       <= ny;
                    xv          <= nxv;
                    yv          <= nyv;
                    color       <= next_color(color, hx | hy);
                    update_done <= 1'b1;
                    bounce      <= hx | hy;
                    busy        <= 1'b0;
                    state       <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bounce_engine.sv
// Directed bench for bounce_engine: four instances with different start conditions share one stimulus.
// A step table drives the main function; hand-written sequences cover collapse, freeze and mid-step reset.
module tb_bounce_engine;

    logic        clk;
    logic        rst_n;
    logic        enable;
    logic [31:0] frame;

    logic [9:0] x0, x1, x2, x3;
    logic [8:0] y0, y1, y2, y3;
    logic [2:0] c0, c1, c2, c3;
    logic       b0, b1, b2, b3;
    logic       u0, u1, u2, u3;
    logic       busy0, busy1, busy2, busy3;

    int ox[4];
    int oy[4];
    int oc[4];
    int ob[4];
    int ou[4];

    int checks   = 0;
    int failures = 0;
    int pulses   = 0;
    int mark;

    typedef struct {
        int x;
        int y;
        int c;
        int b;
    } exp_t;

    logic [31:0] step_frame[3];
    exp_t        tab[3][4];

    // u_main: defaults; u_edge: hits right wall; u_corner: hits top-left corner;
    // u_zero: lands exactly on 0 then reflects, y axis stationary.
    bounce_engine u_main (
        .clk(clk), .rst_n(rst_n), .enable(enable), .frame(frame),
        .box_x(x0), .box_y(y0), .color(c0), .busy(busy0), .update_done(u0), .bounce(b0)
    );
    bounce_engine #(.INIT_X(538), .INIT_Y(50), .INIT_XV(2), .INIT_YV(1)) u_edge (
        .clk(clk), .rst_n(rst_n), .enable(enable), .frame(frame),
        .box_x(x1), .box_y(y1), .color(c1), .busy(busy1), .update_done(u1), .bounce(b1)
    );
    bounce_engine #(.INIT_X(0), .INIT_Y(0), .INIT_XV(-1), .INIT_YV(-1)) u_corner (
        .clk(clk), .rst_n(rst_n), .enable(enable), .frame(frame),
        .box_x(x2), .box_y(y2), .color(c2), .busy(busy2), .update_done(u2), .bounce(b2)
    );
    bounce_engine #(.INIT_X(2), .INIT_Y(0), .INIT_XV(-2), .INIT_YV(0)) u_zero (
        .clk(clk), .rst_n(rst_n), .enable(enable), .frame(frame),
        .box_x(x3), .box_y(y3), .color(c3), .busy(busy3), .update_done(u3), .bounce(b3)
    );

    assign ox[0] = int'(x0);
    assign ox[1] = int'(x1);
    assign ox[2] = int'(x2);
    assign ox[3] = int'(x3);
    assign oy[0] = int'(y0);
    assign oy[1] = int'(y1);
    assign oy[2] = int'(y2);
    assign oy[3] = int'(y3);
    assign oc[0] = int'(c0);
    assign oc[1] = int'(c1);
    assign oc[2] = int'(c2);
    assign oc[3] = int'(c3);
    assign ob[0] = int'(b0);
    assign ob[1] = int'(b1);
    assign ob[2] = int'(b2);
    assign ob[3] = int'(b3);
    assign ou[0] = int'(u0);
    assign ou[1] = int'(u1);
    assign ou[2] = int'(u2);
    assign ou[3] = int'(u3);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (u0)
            pulses++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, actual=running required=finished");
        $fatal(1, "watchdog");
    end

    task automatic step_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
        end
    endtask

    initial begin
        step_frame[0] = 32'd0;
        step_frame[1] = 32'd1;
        step_frame[2] = 32'd2;
        tab[0][0] = '{52, 51, 7, 0};
        tab[0][1] = '{540, 51, 1, 1};
        tab[0][2] = '{0, 0, 1, 1};
        tab[0][3] = '{0, 0, 7, 0};
        tab[1][0] = '{54, 52, 7, 0};
        tab[1][1] = '{538, 52, 1, 0};
        tab[1][2] = '{1, 1, 1, 0};
        tab[1][3] = '{0, 0, 1, 1};
        tab[2][0] = '{56, 53, 7, 0};
        tab[2][1] = '{536, 53, 1, 0};
        tab[2][2] = '{2, 2, 1, 0};
        tab[2][3] = '{2, 0, 1, 0};

        rst_n  = 1'b0;
        enable = 1'b1;
        frame  = 32'hFFFF_FFFF;
        step_clk(3);
        check("reset_x", ox[0], 50);
        check("reset_y", oy[0], 50);
        check("reset_color", oc[0], 7);
        check("reset_busy", int'(busy0), 0);
        check("reset_update_done", ou[0], 0);
        check("reset_bounce", ob[0], 0);

        rst_n = 1'b1;
        step_clk(6);
        check("hold_x", ox[0], 50);
        check("hold_y", oy[0], 50);
        check("hold_busy", int'(busy0), 0);
        check("hold_pulses", pulses, 0);

        for (int s = 0; s < 3; s++) begin
            frame = step_frame[s];
            step_clk(3);
            check($sformatf("s%0d_busy_mid", s), int'(busy0), 1);
            check($sformatf("s%0d_ud_early", s), ou[0], 0);
            check($sformatf("s%0d_x_early", s), ox[0], (s == 0) ? 50 : tab[s-1][0].x);
            step_clk(1);
            for (int d = 0; d < 4; d++) begin
                check($sformatf("s%0d_d%0d_ud", s, d), ou[d], 1);
                check($sformatf("s%0d_d%0d_x", s, d), ox[d], tab[s][d].x);
                check($sformatf("s%0d_d%0d_y", s, d), oy[d], tab[s][d].y);
                check($sformatf("s%0d_d%0d_color", s, d), oc[d], tab[s][d].c);
                check($sformatf("s%0d_d%0d_bounce", s, d), ob[d], tab[s][d].b);
            end
            step_clk(1);
            check($sformatf("s%0d_ud_single", s), ou[0], 0);
            check($sformatf("s%0d_bounce_single", s), ob[1], 0);
            check($sformatf("s%0d_busy_end", s), int'(busy0), 0);
            step_clk(2);
        end

        // Three changes in quick succession collapse into two steps.
        mark  = pulses;
        frame = 32'd3;
        step_clk(1);
        frame = 32'd4;
        step_clk(1);
        frame = 32'd5;
        step_clk(20);
        check("collapse_pulses", pulses - mark, 2);
        check("collapse_x", ox[0], 60);
        check("collapse_y", oy[0], 55);

        // Frozen across five changes, then re-enabled with no fresh change.
        mark   = pulses;
        enable = 1'b0;
        for (int i = 0; i < 5; i++) begin
            frame = frame + 32'd1;
            step_clk(2);
        end
        step_clk(10);
        check("freeze_pulses", pulses - mark, 0);
        check("freeze_x", ox[0], 60);
        enable = 1'b1;
        step_clk(10);
        check("reenable_pulses", pulses - mark, 0);
        check("reenable_x", ox[0], 60);

        // Reset while the step is in CALC_Y.
        mark  = pulses;
        frame = 32'd11;
        step_clk(2);
        check("abort_busy_before", int'(busy0), 1);
        rst_n = 1'b0;
        frame = 32'hFFFF_FFFF;
        #1;
        check("abort_x", ox[0], 50);
        check("abort_y", oy[0], 50);
        check("abort_color", oc[0], 7);
        check("abort_busy", int'(busy0), 0);
        step_clk(2);
        rst_n = 1'b1;
        step_clk(6);
        check("abort_no_pulse", pulses - mark, 0);
        check("abort_x_hold", ox[0], 50);
        frame = 32'd0;
        step_clk(3);
        check("resume_ud_early", ou[0], 0);
        step_clk(1);
        check("resume_ud", ou[0], 1);
        check("resume_x", ox[0], 52);
        check("resume_y", oy[0], 51);
        check("resume_color", oc[0], 7);
        step_clk(1);
        check("resume_ud_single", ou[0], 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
